// File: rtl/grid_pkg.sv
// rtl/grid_pkg.sv - grid geometry, cell codes and address helpers
package grid_pkg;

    localparam int ROWS     = 60;
    localparam int COLS     = 80;
    localparam int BORDER_W = 2;
    localparam int ADDR_W   = 13;

    typedef logic [1:0] cell_t;

    localparam cell_t EMPTY    = 2'd0;
    localparam cell_t TRAIL_P1 = 2'd1;
    localparam cell_t BORDER   = 2'd2;
    localparam cell_t TRAIL_P2 = 2'd3;

    // row*80 as shift-add so no multiplier is inferred
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [5:0] row, input logic [6:0] col);
        return ({7'd0, row} << 6) + ({7'd0, row} << 4) + {6'd0, col};
    endfunction

    function automatic logic cell_in_range(input logic [5:0] row, input logic [6:0] col);
        return (row < 6'(ROWS)) && (col < 7'(COLS));
    endfunction

    function automatic logic cell_is_border(input logic [5:0] row, input logic [6:0] col);
        return (row < 6'(BORDER_W)) || (row > 6'(ROWS - BORDER_W - 1)) ||
               (col < 7'(BORDER_W)) || (col > 7'(COLS - BORDER_W - 1));
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter; last=1 means requester 1 won most recently
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/grid_access_arbiter.sv
// rtl/grid_access_arbiter.sv - grid RAM port owner: border/clear init, then round-robin player access
import grid_pkg::*;

module grid_access_arbiter (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        reiniciar,
    output logic        clear_busy,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [5:0]  p1_row,
    input  logic [6:0]  p1_col,
    input  logic [1:0]  p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [1:0]  p1_rdata,
    input  logic        p2_req,
    input  logic        p2_we,
    input  logic [5:0]  p2_row,
    input  logic [6:0]  p2_col,
    input  logic [1:0]  p2_wdata,
    output logic        p2_gnt,
    output logic        p2_rvalid,
    output logic [1:0]  p2_rdata,
    output logic [12:0] ram_addr,
    output logic        ram_we,
    output logic [1:0]  ram_wdata,
    input  logic [1:0]  ram_rdata
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_ARB   = 1'b1;

    logic [0:0] state;
    logic [5:0] row_cnt;
    logic [6:0] col_cnt;
    logic       last_gnt;
    logic       p1_rd_pend, p1_rd_oor;
    logic       p2_rd_pend, p2_rd_oor;

    logic       arb_open;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       acc_we;
    logic [5:0] acc_row;
    logic [6:0] acc_col;
    logic [1:0] acc_wdata;
    logic       acc_oor;

    assign arb_open = (state == ST_ARB) && !reiniciar && !reset;
    assign req      = {p2_req, p1_req} & {2{arb_open}};

    rr_arb2 u_rr_arb2 (
        .req  (req),
        .last (last_gnt),
        .gnt  (gnt)
    );

    assign p1_gnt     = gnt[0];
    assign p2_gnt     = gnt[1];
    assign clear_busy = (state == ST_CLEAR);

    assign acc_we    = gnt[1] ? p2_we    : p1_we;
    assign acc_row   = gnt[1] ? p2_row   : p1_row;
    assign acc_col   = gnt[1] ? p2_col   : p1_col;
    assign acc_wdata = gnt[1] ? p2_wdata : p1_wdata;
    assign acc_oor   = !cell_in_range(acc_row, acc_col);

    // Out-of-range accesses are granted but never reach the RAM
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = EMPTY;
        if (!reset) begin
            if (state == ST_CLEAR) begin
                ram_addr  = cell_addr(row_cnt, col_cnt);
                ram_we    = 1'b1;
                ram_wdata = cell_is_border(row_cnt, col_cnt) ? BORDER : EMPTY;
            end else if ((|gnt) && !acc_oor) begin
                ram_addr  = cell_addr(acc_row, acc_col);
                ram_we    = acc_we;
                ram_wdata = acc_we ? acc_wdata : EMPTY;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state      <= ST_CLEAR;
            row_cnt    <= '0;
            col_cnt    <= '0;
            last_gnt   <= 1'b1;
            p1_rd_pend <= 1'b0;
            p1_rd_oor  <= 1'b0;
            p2_rd_pend <= 1'b0;
            p2_rd_oor  <= 1'b0;
        end else begin
            p1_rd_pend <= gnt[0] && !p1_we;
            p1_rd_oor  <= acc_oor;
            p2_rd_pend <= gnt[1] && !p2_we;
            p2_rd_oor  <= acc_oor;

            if (gnt[0]) begin
                last_gnt <= 1'b0;
            end else if (gnt[1]) begin
                last_gnt <= 1'b1;
            end

            if (reiniciar) begin
                state   <= ST_CLEAR;
                row_cnt <= '0;
                col_cnt <= '0;
            end else if (state == ST_CLEAR) begin
                if (col_cnt == 7'(COLS - 1)) begin
                    col_cnt <= '0;
                    if (row_cnt == 6'(ROWS - 1)) begin
                        row_cnt <= '0;
                        state   <= ST_ARB;
                    end else begin
                        row_cnt <= row_cnt + 6'd1;
                    end
                end else begin
                    col_cnt <= col_cnt + 7'd1;
                end
            end
        end
    end

    // RAM read data arrives the cycle after the grant; out-of-range reads report a collision
    assign p1_rvalid = p1_rd_pend;
    assign p1_rdata  = p1_rd_pend ? (p1_rd_oor ? BORDER : ram_rdata) : EMPTY;
    assign p2_rvalid = p2_rd_pend;
    assign p2_rdata  = p2_rd_pend ? (p2_rd_oor ? BORDER : ram_rdata) : EMPTY;

endmodule
